// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (640x480@60 defaults) and the decode record
// used by the pixel timer.
package vga_timing_pkg;

    // Pixel clock divider default: sys_clk cycles per pixel
    localparam int DEF_DIV    = 2;

    // Horizontal timing in pixels
    localparam int DEF_H_VIS  = 640;
    localparam int DEF_H_FP   = 16;
    localparam int DEF_H_SYNC = 96;
    localparam int DEF_H_BP   = 48;

    // Vertical timing in lines
    localparam int DEF_V_VIS  = 480;
    localparam int DEF_V_FP   = 10;
    localparam int DEF_V_SYNC = 2;
    localparam int DEF_V_BP   = 33;

    // Counter width for hcount/vcount
    localparam int DEF_CW     = 11;

    // Region flags decoded from the next count value
    typedef struct packed {
        logic h_act;   // inside the horizontal sync window
        logic v_act;   // inside the vertical sync window
        logic vis;     // inside the visible area
    } sync_dec_t;

endpackage

// File: rtl/vga_clk_ce.sv
// Pixel clock divider: counts DIV sys_clk cycles per pixel, producing a
// registered pixel clock for the DAC and a one-cycle pixel enable.
// pix_adv is the combinational "this edge completes a pixel" strobe the
// timing counters use so they change on the same edge pixel_ce rises.
module vga_clk_ce
    import vga_timing_pkg::*;
#(
    parameter int DIV = DEF_DIV
) (
    input  logic sys_clk,
    input  logic clrn,
    input  logic en,
    output logic vga_clk,
    output logic pixel_ce,
    output logic pix_adv
);

    localparam int             DW     = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0]  D_LAST = DW'(DIV - 1);
    localparam logic [DW-1:0]  D_HALF = DW'(DIV / 2);

    logic [DW-1:0] r_d;
    logic          r_vclk;
    logic          r_ce;
    logic [DW-1:0] w_d_nxt;
    logic          w_wrap;

    assign w_wrap  = (r_d == D_LAST);
    assign w_d_nxt = !en ? r_d : (w_wrap ? '0 : r_d + DW'(1));
    assign pix_adv = en & w_wrap;

    // Divider phase, pixel clock level and pixel enable; all hold when en is low
    always_ff @(posedge sys_clk or negedge clrn) begin
        if (!clrn) begin
            r_d    <= '0;
            r_vclk <= 1'b1;
            r_ce   <= 1'b0;
        end else begin
            r_d    <= w_d_nxt;
            r_vclk <= (w_d_nxt < D_HALF);
            r_ce   <= en & w_wrap;
        end
    end

    assign vga_clk  = r_vclk;
    assign pixel_ce = r_ce;

endmodule

// File: rtl/vga_pixel_timer.sv
// VGA raster timer: pixel divider plus horizontal/vertical counters with
// registered sync, blanking and line/frame markers. Every decoded output is
// computed from the next count value so it lines up with hcount/vcount.
module vga_pixel_timer
    import vga_timing_pkg::*;
#(
    parameter int DIV    = DEF_DIV,
    parameter int H_VIS  = DEF_H_VIS,
    parameter int H_FP   = DEF_H_FP,
    parameter int H_SYNC = DEF_H_SYNC,
    parameter int H_BP   = DEF_H_BP,
    parameter int V_VIS  = DEF_V_VIS,
    parameter int V_FP   = DEF_V_FP,
    parameter int V_SYNC = DEF_V_SYNC,
    parameter int V_BP   = DEF_V_BP,
    parameter bit HS_POL = 1'b0,
    parameter bit VS_POL = 1'b0,
    parameter int CW     = DEF_CW
) (
    input  logic          sys_clk,
    input  logic          clrn,
    input  logic          en,
    output logic          vga_clk,
    output logic          pixel_ce,
    output logic [CW-1:0] hcount,
    output logic [CW-1:0] vcount,
    output logic          hsync,
    output logic          vsync,
    output logic          vga_blank_n,
    output logic          vga_sync_n,
    output logic          line_start,
    output logic          frame_start
);

    // Window boundaries, fixed at elaboration
    localparam int            H_TOT    = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int            V_TOT    = V_VIS + V_FP + V_SYNC + V_BP;
    localparam logic [CW-1:0] H_LAST   = CW'(H_TOT - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOT - 1);
    localparam logic [CW-1:0] H_VIS_E  = CW'(H_VIS);
    localparam logic [CW-1:0] V_VIS_E  = CW'(V_VIS);
    localparam logic [CW-1:0] HS_BEG   = CW'(H_VIS + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_VIS + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_BEG   = CW'(V_VIS + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_VIS + V_FP + V_SYNC);

    logic          w_adv;
    logic          w_h_last;
    logic          w_v_last;
    logic [CW-1:0] w_h_nxt;
    logic [CW-1:0] w_v_nxt;
    sync_dec_t     w_dec;

    logic [CW-1:0] r_h;
    logic [CW-1:0] r_v;
    logic          r_hs;
    logic          r_vs;
    logic          r_blank_n;
    logic          r_sync_n;
    logic          r_ls;
    logic          r_fs;

    vga_clk_ce #(
        .DIV      (DIV)
    ) u_clk_ce (
        .sys_clk  (sys_clk),
        .clrn     (clrn),
        .en       (en),
        .vga_clk  (vga_clk),
        .pixel_ce (pixel_ce),
        .pix_adv  (w_adv)
    );

    assign w_h_last = (r_h == H_LAST);
    assign w_v_last = (r_v == V_LAST);

    // Next raster position: h steps per pixel, v steps on the h wrap
    always_comb begin
        w_h_nxt = r_h;
        w_v_nxt = r_v;
        if (w_adv) begin
            w_h_nxt = w_h_last ? '0 : r_h + CW'(1);
            if (w_h_last) begin
                w_v_nxt = w_v_last ? '0 : r_v + CW'(1);
            end
        end
    end

    // Region decode of the next position
    always_comb begin
        w_dec       = '0;
        w_dec.h_act = (w_h_nxt >= HS_BEG) && (w_h_nxt < HS_END);
        w_dec.v_act = (w_v_nxt >= VS_BEG) && (w_v_nxt < VS_END);
        w_dec.vis   = (w_h_nxt < H_VIS_E) && (w_v_nxt < V_VIS_E);
    end

    // Counters and decoded outputs; with en low w_adv is 0 so everything holds
    always_ff @(posedge sys_clk or negedge clrn) begin
        if (!clrn) begin
            r_h       <= '0;
            r_v       <= '0;
            r_hs      <= ~HS_POL;
            r_vs      <= ~VS_POL;
            r_blank_n <= 1'b1;
            r_sync_n  <= 1'b1;
            r_ls      <= 1'b0;
            r_fs      <= 1'b0;
        end else begin
            r_h       <= w_h_nxt;
            r_v       <= w_v_nxt;
            r_hs      <= w_dec.h_act ? HS_POL : ~HS_POL;
            r_vs      <= w_dec.v_act ? VS_POL : ~VS_POL;
            r_blank_n <= w_dec.vis;
            r_sync_n  <= ~(w_dec.h_act | w_dec.v_act);
            r_ls      <= w_adv & w_h_last;
            r_fs      <= w_adv & w_h_last & w_v_last;
        end
    end

    assign hcount      = r_h;
    assign vcount      = r_v;
    assign hsync       = r_hs;
    assign vsync       = r_vs;
    assign vga_blank_n = r_blank_n;
    assign vga_sync_n  = r_sync_n;
    assign line_start  = r_ls;
    assign frame_start = r_fs;

endmodule
